// File: rtl/program_loader_pkg.sv
// Shared constants for the boot-time instruction-memory loader.
// State codes are plain 3-bit constants so older code can still compare against them.
package program_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_LEN_HI = 3'd0;
  localparam state_t S_LEN_LO = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_WRITE  = 3'd3;
  localparam state_t S_HOLD   = 3'd4;
  localparam state_t S_RUN    = 3'd5;
  localparam state_t S_ERR    = 3'd6;

  localparam int unsigned HEADER_BYTES   = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the program loader.
// The master side is the loader; the slave side is the byte source and the memory.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);

  logic [7:0]            byteIn;
  logic                  byteValid;
  logic                  byteReady;
  logic                  imemWrEn;
  logic [ADDR_WIDTH-1:0] imemAddr;
  logic [31:0]           imemWrData;

  modport master (
    input  byteIn,
    input  byteValid,
    output byteReady,
    output imemWrEn,
    output imemAddr,
    output imemWrData
  );

  modport slave (
    output byteIn,
    output byteValid,
    input  byteReady,
    input  imemWrEn,
    input  imemAddr,
    input  imemWrData
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Shifts image bytes in MSB first and flags the cycle in which the final byte of a
// word arrives; word_o is only meaningful while word_ready_o is high.
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  localparam logic [1:0] LastIdx = 2'(BYTES_PER_WORD - 1);

  logic [23:0] shift_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clr_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (en_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      idx_q   <= idx_q + 2'd1;
    end
  end

  // The last byte is merged combinationally so the write can be registered in the same cycle.
  assign word_ready_o = en_i && (idx_q == LastIdx);
  assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/program_loader.sv
// Boot loader: reads a length-prefixed big-endian byte image, writes it to instruction
// memory, then releases the core from reset after a fixed hold time.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned MAX_WORDS   = 1024,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  program_loader_if.master       bus,
  input  logic                   reload,
  output logic                   cpuRst,
  output logic                   loadDone,
  output logic                   loadErr,
  output logic [15:0]            wordCount
);

  localparam int unsigned LenW     = 8 * HEADER_BYTES;
  localparam logic [LenW:0] MaxWords = (LenW + 1)'(MAX_WORDS);
  localparam logic [7:0]  HoldLast = 8'(HOLD_CYCLES - 1);

  state_t                state_q, state_d;
  logic [LenW-1:0]       len_q;
  logic [15:0]           count_q;
  logic [7:0]            hold_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  cpu_rst_q, done_q, err_q;

  logic                  xfer;
  logic [LenW-1:0]       len_full;
  logic [15:0]           count_inc;
  logic [31:0]           word;
  logic                  word_ready;
  logic                  reload_ok;

  assign bus.byteReady = !rst && (state_q == S_LEN_HI || state_q == S_LEN_LO ||
                                  state_q == S_DATA);
  assign xfer      = bus.byteValid && bus.byteReady;
  assign len_full  = {len_q[LenW-1:8], bus.byteIn};
  assign count_inc = count_q + 16'd1;
  assign reload_ok = reload && (state_q == S_RUN || state_q == S_ERR);

  program_loader_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (state_q == S_LEN_LO),
    .en_i         (xfer && state_q == S_DATA),
    .byte_i       (bus.byteIn),
    .word_o       (word),
    .word_ready_o (word_ready)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN_HI: if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_full == '0)                 state_d = S_HOLD;
          else if ({1'b0, len_full} > MaxWords) state_d = S_ERR;
          else                                state_d = S_DATA;
        end
      end
      S_DATA:  if (word_ready) state_d = S_WRITE;
      S_WRITE: state_d = (count_inc == len_q) ? S_HOLD : S_DATA;
      S_HOLD:  if (hold_q == HoldLast) state_d = S_RUN;
      S_RUN,
      S_ERR:   if (reload) state_d = S_LEN_HI;
      default: state_d = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LEN_HI;
      len_q     <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_LEN_HI && xfer) len_q[LenW-1:8] <= bus.byteIn;
      if (state_q == S_LEN_LO && xfer) len_q[7:0] <= bus.byteIn;
      wr_en_q <= word_ready;
      if (word_ready) begin
        addr_q <= count_q[ADDR_WIDTH-1:0];
        data_q <= word;
      end
      hold_q <= (state_q == S_HOLD) ? hold_q + 8'd1 : '0;
      if (state_q == S_WRITE) count_q <= count_inc;
      else if (reload_ok)     count_q <= '0;
      // Status flags follow the next state so they stay registered and glitch-free.
      cpu_rst_q <= (state_d != S_RUN);
      done_q    <= (state_d == S_RUN);
      err_q     <= (state_d == S_ERR);
    end
  end

  assign bus.imemWrEn   = wr_en_q;
  assign bus.imemAddr   = addr_q;
  assign bus.imemWrData = data_q;
  assign cpuRst         = cpu_rst_q;
  assign loadDone       = done_q;
  assign loadErr        = err_q;
  assign wordCount      = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected memory writes, a
// negedge monitor pops and compares them whenever imemWrEn is seen.
module tb_program_loader;

  localparam int unsigned HOLD = 4;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reload;
  logic        cpuRst, loadDone, loadErr;
  logic [15:0] wordCount;

  program_loader_if #(.ADDR_WIDTH(10)) bus ();

  program_loader #(
    .ADDR_WIDTH  (10),
    .MAX_WORDS   (1024),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .reload    (reload),
    .cpuRst    (cpuRst),
    .loadDone  (loadDone),
    .loadErr   (loadErr),
    .wordCount (wordCount)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   checks = 0, failures = 0;
  int   wr_total = 0, last_wr_cyc = 0, acc_cyc = 0;
  logic prev_wr = 1'b0;
  logic track = 1'b0;
  int   rdy_low = 0, trk_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr = 1'b0;
    end else begin
      if (bus.imemWrEn) begin
        wr_total++;
        last_wr_cyc = cyc;
        chk("wr_not_back_to_back", 32'(prev_wr), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   bus.imemAddr, bus.imemWrData);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.imemAddr), 32'(mon_e.addr));
          chk("wr_data", bus.imemWrData, mon_e.data);
        end
      end
      if (track && trk_wr < 2) begin
        if (!bus.byteReady) rdy_low++;
        if (bus.imemWrEn) begin
          trk_wr++;
          chk("stall_ready_low_in_write", 32'(bus.byteReady), 32'd0);
        end
      end
      prev_wr = bus.imemWrEn;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n = 0;
    @(negedge clk);
    bus.byteIn    = b;
    bus.byteValid = 1'b1;
    while (!bus.byteReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("byte_accept_timeout", 32'(bus.byteReady), 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    if (stall) begin
      repeat (3) begin
        @(negedge clk);
        bus.byteValid = 1'b0;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [9:0] a, input bit stall);
    wr_t e;
    e.addr = a;
    e.data = w;
    exp_q.push_back(e);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], stall);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.byteValid = 1'b0;
  endtask

  task automatic wait_cpu_low(output int c);
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (!cpuRst) break;
      n++;
    end
    if (n >= 60) chk("cpurst_release_timeout", 32'(cpuRst), 32'd0);
    c = cyc;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  int c, last_acc, hdr;

  initial begin
    rst = 1'b1;
    reload = 1'b0;
    bus.byteValid = 1'b0;
    bus.byteIn = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_byteready", 32'(bus.byteReady), 32'd0);
    chk("rst_wren", 32'(bus.imemWrEn), 32'd0);
    chk("rst_addr", 32'(bus.imemAddr), 32'd0);
    chk("rst_data", bus.imemWrData, 32'd0);
    chk("rst_cpurst", 32'(cpuRst), 32'd1);
    chk("rst_loaddone", 32'(loadDone), 32'd0);
    chk("rst_loaderr", 32'(loadErr), 32'd0);
    chk("rst_wordcount", 32'(wordCount), 32'd0);
    rst = 1'b0;

    // Basic load, byteValid held high.
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(32'h20010005, 10'd0, 1'b0);
    send_word(32'hFC000000, 10'd1, 1'b0);
    last_acc = acc_cyc;
    idle();
    wait_cpu_low(c);
    chk("basic_write_latency", 32'(last_wr_cyc - last_acc), 32'd1);
    chk("basic_cpurst_delay", 32'(c - last_wr_cyc), 32'd5);
    chk("basic_wordcount", 32'(wordCount), 32'd2);
    chk("basic_loaddone", 32'(loadDone), 32'd1);
    chk("basic_writes", 32'(wr_total), 32'd2);

    // Bytes offered while running are not taken.
    @(negedge clk);
    bus.byteIn = 8'hAA;
    bus.byteValid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("run_ignores_bytes", 32'(bus.byteReady), 32'd0);
    end
    bus.byteValid = 1'b0;
    chk("run_wordcount_held", 32'(wordCount), 32'd2);
    chk("run_cpurst_low", 32'(cpuRst), 32'd0);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_cpurst_high", 32'(cpuRst), 32'd1);
    chk("reload_loaddone_low", 32'(loadDone), 32'd0);
    chk("reload_wordcount_zero", 32'(wordCount), 32'd0);
    chk("reload_byteready", 32'(bus.byteReady), 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'h8C220004, 10'd0, 1'b0);
    idle();
    wait_cpu_low(c);
    chk("reload_writes", 32'(wr_total), 32'd3);
    chk("reload_wordcount", 32'(wordCount), 32'd1);

    // Stalled stream: three idle cycles between every byte.
    pulse_reload();
    rdy_low = 0;
    trk_wr = 0;
    track = 1'b1;
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(32'h20010005, 10'd0, 1'b1);
    send_word(32'hFC000000, 10'd1, 1'b1);
    wait_cpu_low(c);
    track = 1'b0;
    chk("stall_ready_low_cycles", 32'(rdy_low), 32'd2);
    chk("stall_tracked_writes", 32'(trk_wr), 32'd2);
    chk("stall_cpurst_delay", 32'(c - last_wr_cyc), 32'(HOLD + 1));
    chk("stall_writes", 32'(wr_total), 32'd5);

    // Empty image.
    pulse_reload();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    hdr = acc_cyc;
    idle();
    wait_cpu_low(c);
    chk("empty_cpurst_delay", 32'(c - hdr), 32'(HOLD + 1));
    chk("empty_no_writes", 32'(wr_total), 32'd5);
    chk("empty_wordcount", 32'(wordCount), 32'd0);
    chk("empty_loaddone", 32'(loadDone), 32'd1);

    // Oversize header 1025.
    pulse_reload();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    bus.byteIn = 8'h55;
    repeat (2) @(negedge clk);
    chk("ovs_loaderr", 32'(loadErr), 32'd1);
    chk("ovs_cpurst", 32'(cpuRst), 32'd1);
    chk("ovs_byteready", 32'(bus.byteReady), 32'd0);
    chk("ovs_loaddone", 32'(loadDone), 32'd0);
    chk("ovs_wordcount", 32'(wordCount), 32'd0);
    bus.byteValid = 1'b0;
    chk("ovs_no_writes", 32'(wr_total), 32'd5);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("ovs_reload_clears_err", 32'(loadErr), 32'd0);
    chk("ovs_reload_byteready", 32'(bus.byteReady), 32'd1);

    // Reset in the middle of word 1.
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(32'h11223344, 10'd0, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    @(negedge clk);
    bus.byteValid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_wren", 32'(bus.imemWrEn), 32'd0);
    chk("midrst_addr", 32'(bus.imemAddr), 32'd0);
    chk("midrst_data", bus.imemWrData, 32'd0);
    chk("midrst_cpurst", 32'(cpuRst), 32'd1);
    chk("midrst_wordcount", 32'(wordCount), 32'd0);
    chk("midrst_byteready", 32'(bus.byteReady), 32'd0);
    chk("midrst_loaddone", 32'(loadDone), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(32'hA1B2C3D4, 10'd0, 1'b0);
    send_word(32'h0F1E2D3C, 10'd1, 1'b0);
    idle();
    wait_cpu_low(c);
    chk("midrst_reload_writes", 32'(wr_total), 32'd8);
    chk("midrst_reload_wordcount", 32'(wordCount), 32'd2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
